// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath geometry, ALU function codes and the
// issue-stage occupancy encoding, plus the operand-read helper.
package cpu_pkg;

  localparam int DW    = 16;
  localparam int RAW   = 3;
  localparam int NREGS = 8;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SHL  = 3'd4;
  localparam logic [2:0] ALU_SHR  = 3'd5;
  localparam logic [2:0] ALU_LDHI = 3'd6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // r0 is constant zero; otherwise the in-flight result wins over the stale register copy.
  function automatic logic [DW-1:0] read_operand(
    input logic [RAW-1:0] rs,
    input logic           inflight_valid,
    input logic [RAW-1:0] inflight_rd,
    input logic [DW-1:0]  inflight_data,
    input logic [DW-1:0]  rf_data
  );
    logic [DW-1:0] val;
    if (rs == {RAW{1'b0}}) begin
      val = {DW{1'b0}};
    end else if (inflight_valid && (inflight_rd == rs)) begin
      val = inflight_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Op-in / ALU / result-out bundle of the issue stage. The slave side is the
// stage itself; the master side is the op source, ALU and result consumer.
interface alu_issue_stage_if;
  import cpu_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_f;
  logic [RAW-1:0] in_rd;
  logic [RAW-1:0] in_rs1;
  logic [RAW-1:0] in_rs2;
  logic           in_use_imm;
  logic [DW-1:0]  in_imm;

  logic [DW-1:0]  alu_x;
  logic [DW-1:0]  alu_y;
  logic [2:0]     alu_f;
  logic [DW-1:0]  alu_out;

  logic           res_valid;
  logic           res_ready;
  logic [RAW-1:0] res_rd;
  logic [DW-1:0]  res_data;

  modport master (
    output in_valid, in_f, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    output alu_out, res_ready,
    input  in_ready, alu_x, alu_y, alu_f, res_valid, res_rd, res_data
  );

  modport slave (
    input  in_valid, in_f, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    input  alu_out, res_ready,
    output in_ready, alu_x, alu_y, alu_f, res_valid, res_rd, res_data
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one clocked write port;
// r0 is never stored and always reads as zero.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int NR = NREGS,
  parameter int W  = DW,
  parameter int AW = RAW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd
);

  logic [W-1:0] mem_r [NR];

  // Storage update; writes aimed at r0 are discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (we && (wa != {AW{1'b0}})) begin
      mem_r[wa] <= wd;
    end
  end

  // Read ports with r0 forced to zero
  always_comb begin
    rd1 = {W{1'b0}};
    rd2 = {W{1'b0}};
    if (ra1 != {AW{1'b0}}) begin
      rd1 = mem_r[ra1];
    end else begin
      rd1 = {W{1'b0}};
    end
    if (ra2 != {AW{1'b0}}) begin
      rd2 = mem_r[ra2];
    end else begin
      rd2 = {W{1'b0}};
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage in front of the 16-bit ALU: reads and forwards operands,
// holds one op in flight and writes its result back when the consumer takes it.
module alu_issue_stage
  import cpu_pkg::*;
(
  input logic              clk,
  input logic              reset,
  alu_issue_stage_if.slave bus
);

  stage_state_e   state_r;
  stage_state_e   state_next_s;
  logic           s1_valid_s;
  logic           accept_s;
  logic           fire_s;
  logic [DW-1:0]  rf_rd1_s;
  logic [DW-1:0]  rf_rd2_s;
  logic [DW-1:0]  op_x_s;
  logic [DW-1:0]  op_y_s;
  logic [DW-1:0]  alu_x_r;
  logic [DW-1:0]  alu_y_r;
  logic [2:0]     alu_f_r;
  logic [RAW-1:0] res_rd_r;

  assign s1_valid_s   = (state_r == ST_FULL);
  assign bus.in_ready = !s1_valid_s || bus.res_ready;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign fire_s       = s1_valid_s && bus.res_ready;

  regfile_2r1w #(.NR(NREGS), .W(DW), .AW(RAW)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (bus.in_rs1),
    .rd1   (rf_rd1_s),
    .ra2   (bus.in_rs2),
    .rd2   (rf_rd2_s),
    .we    (fire_s),
    .wa    (res_rd_r),
    .wd    (bus.alu_out)
  );

  // Operand selection; the immediate path never looks at rs2 for forwarding
  always_comb begin
    op_x_s = read_operand(bus.in_rs1, s1_valid_s, res_rd_r, bus.alu_out, rf_rd1_s);
    op_y_s = {DW{1'b0}};
    if (bus.in_use_imm) begin
      op_y_s = bus.in_imm;
    end else begin
      op_y_s = read_operand(bus.in_rs2, s1_valid_s, res_rd_r, bus.alu_out, rf_rd2_s);
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Occupancy next state: an accept always refills, a lone fire drains
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_next_s = ST_FULL;
        end else if (fire_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        state_next_s = ST_EMPTY;
      end
    endcase
  end

  // Stage-1 register loads only on accept, so a stall freezes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_x_r  <= {DW{1'b0}};
      alu_y_r  <= {DW{1'b0}};
      alu_f_r  <= 3'd0;
      res_rd_r <= {RAW{1'b0}};
    end else if (accept_s) begin
      alu_x_r  <= op_x_s;
      alu_y_r  <= op_y_s;
      alu_f_r  <= bus.in_f;
      res_rd_r <= bus.in_rd;
    end
  end

  assign bus.alu_x     = alu_x_r;
  assign bus.alu_y     = alu_y_r;
  assign bus.alu_f     = alu_f_r;
  assign bus.res_valid = s1_valid_s;
  assign bus.res_rd    = res_rd_r;
  assign bus.res_data  = bus.alu_out;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, architectural register model,
// directed table, ALU sweep, reset-during-stall and randomized traffic.
module tb_alu_issue_stage;
  import cpu_pkg::*;

  typedef struct {
    logic        v;
    logic [2:0]  f;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        ui;
    logic [15:0] imm;
    logic        rdy;
    logic        chk;
    logic [15:0] ex;
    logic [15:0] ey;
  } vec_t;

  logic clk;
  logic reset;
  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_rf [8];
  logic        m_v;
  logic [2:0]  m_f;
  logic [2:0]  m_rd;
  logic [15:0] m_x;
  logic [15:0] m_y;
  logic        h_chk;
  logic [15:0] h_x;
  logic [15:0] h_y;
  vec_t        tbl [$];
  vec_t        last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] alu_ref(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
    case (f)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x << y[3:0];
      3'd5:    return x >> y[3:0];
      3'd6:    return {x[6:0], y[8:0]};
      default: return x ^ y;
    endcase
  endfunction

  always_comb bus.alu_out = alu_ref(bus.alu_f, bus.alu_x, bus.alu_y);

  function automatic vec_t mk(input logic v, input logic [2:0] f, input logic [2:0] rd,
                              input logic [2:0] rs1, input logic [2:0] rs2, input logic ui,
                              input logic [15:0] imm, input logic rdy, input logic c,
                              input logic [15:0] ex, input logic [15:0] ey);
    vec_t t;
    t.v = v; t.f = f; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.ui = ui;
    t.imm = imm; t.rdy = rdy; t.chk = c; t.ex = ex; t.ey = ey;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_v   = 1'b0;
    h_chk = 1'b0;
  endtask

  // One clock: drive, check against the model, advance the model, then clock.
  task automatic cycle(input vec_t t);
    logic [15:0] arch [8];
    logic        acc;
    logic        fire;
    bus.in_valid   = t.v;
    bus.in_f       = t.f;
    bus.in_rd      = t.rd;
    bus.in_rs1     = t.rs1;
    bus.in_rs2     = t.rs2;
    bus.in_use_imm = t.ui;
    bus.in_imm     = t.imm;
    bus.res_ready  = t.rdy;
    #1;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_v || t.rdy)});
    chk("res_valid", {31'd0, bus.res_valid}, {31'd0, m_v});
    if (m_v) begin
      chk("alu_x", {16'd0, bus.alu_x}, {16'd0, m_x});
      chk("alu_y", {16'd0, bus.alu_y}, {16'd0, m_y});
      chk("alu_f", {29'd0, bus.alu_f}, {29'd0, m_f});
      chk("res_rd", {29'd0, bus.res_rd}, {29'd0, m_rd});
      chk("res_data", {16'd0, bus.res_data}, {16'd0, alu_ref(m_f, m_x, m_y)});
      if (h_chk) begin
        chk("table_x", {16'd0, bus.alu_x}, {16'd0, h_x});
        chk("table_y", {16'd0, bus.alu_y}, {16'd0, h_y});
      end
    end
    // Architectural view: every accepted op has completed
    for (int i = 0; i < 8; i++) arch[i] = m_rf[i];
    if (m_v && m_rd != 3'd0) arch[m_rd] = alu_ref(m_f, m_x, m_y);
    acc  = t.v && (!m_v || t.rdy);
    fire = m_v && t.rdy;
    if (fire && m_rd != 3'd0) m_rf[m_rd] = alu_ref(m_f, m_x, m_y);
    if (acc) begin
      m_v = 1'b1; m_f = t.f; m_rd = t.rd;
      m_x = arch[t.rs1];
      m_y = t.ui ? t.imm : arch[t.rs2];
      h_chk = t.chk; h_x = t.ex; h_y = t.ey;
    end else if (fire) begin
      m_v = 1'b0;
      h_chk = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t bub;
    vec_t t;
    bub = mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000);
    bus.in_valid = 1'b0; bus.in_f = 3'd0; bus.in_rd = 3'd0; bus.in_rs1 = 3'd0;
    bus.in_rs2 = 3'd0; bus.in_use_imm = 1'b0; bus.in_imm = 16'h0000; bus.res_ready = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_alu_x", {16'd0, bus.alu_x}, 32'd0);
    chk("rst_alu_y", {16'd0, bus.alu_y}, 32'd0);
    chk("rst_alu_f", {29'd0, bus.alu_f}, 32'd0);
    chk("rst_res_rd", {29'd0, bus.res_rd}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table: op fields, res_ready, hand-computed operands of that op
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0000, 16'h0005));
    tbl.push_back(bub);
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0005, 16'h0001));
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0007, 1'b1, 1'b1, 16'h0000, 16'h0007));
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0007, 16'h0007));
    tbl.push_back(bub);
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd0, 3'd2, 3'd1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000E, 16'h0007));
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'hFFFF));
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000));
    tbl.push_back(bub);
    tbl.push_back(mk(1'b1, ALU_SUB, 3'd6, 3'd3, 3'd0, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0006, 16'h0002));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b1, ALU_OR, 3'd6, 3'd6, 3'd0, 1'b1, 16'h00F0, 1'b0, 1'b0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1'b1, ALU_OR, 3'd6, 3'd6, 3'd0, 1'b1, 16'h00F0, 1'b1, 1'b1, 16'h0004, 16'h00F0));
    tbl.push_back(bub);
    tbl.push_back(mk(1'b1, ALU_ADD, 3'd0, 3'd6, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00F4, 16'h0006));
    tbl.push_back(bub);
    foreach (tbl[i]) cycle(tbl[i]);

    // ALU function sweep with results read back from the register file
    cycle(mk(1'b1, ALU_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h0000, 16'h1234));
    for (int f = 0; f < 8; f++) begin
      cycle(mk(1'b1, 3'(f), 3'd5, 3'd4, 3'd0, 1'b1, 16'h0003, 1'b1, 1'b1, 16'h1234, 16'h0003));
      cycle(bub);
      cycle(mk(1'b1, ALU_ADD, 3'd0, 3'd5, 3'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000));
      if (f == 6) chk("ldhi_value", {16'd0, bus.alu_x}, 32'h0000_6803);
    end
    cycle(bub);

    // Reset while an op is stalled: it must vanish without writing r7
    cycle(mk(1'b1, ALU_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0BAD, 1'b1, 1'b0, 16'h0000, 16'h0000));
    cycle(mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000));
    #2 reset = 1'b1;
    #1;
    chk("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("midrst_res_rd", {29'd0, bus.res_rd}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(mk(1'b1, ALU_ADD, 3'd0, 3'd7, 3'd7, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000));
    cycle(bub);

    // Randomized traffic; an unaccepted op is held until taken
    last = bub;
    for (int n = 0; n < 400; n++) begin
      if (last.v && !(!m_v || last.rdy)) begin
        t = last;
      end else begin
        t = mk(($urandom % 4) != 0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
               1'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      t.rdy = ($urandom % 4) != 0;
      last = t;
      cycle(t);
    end
    cycle(bub);
    cycle(bub);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
